decoder: RTL and testbench

- Per-core instruction decoder for the miniGPU 16-bit ISA.
- During the DECODE pipeline state, it registers the register-address fields, the immediate and the branch condition. It also registers one-hot-style control signals for the ALU, LSU, PC unit and register file.
- It sits between the fetcher (instruction source) and the per-thread execution units. Its outputs are shared by all threads of the core.

---
 rtl/decoder_pkg.sv | 51 +++++
 rtl/decoder.sv | 117 +++++++++++
 tb/tb_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the miniGPU instruction decoder: opcodes, core states,
// ALU op selects, write-back mux selects and the bundled control word.
package decoder_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_BRNZP = 4'b0001,
    OP_CMP   = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_MUL   = 4'b0101,
    OP_DIV   = 4'b0110,
    OP_LDR   = 4'b0111,
    OP_STR   = 4'b1000,
    OP_CONST = 4'b1001,
    OP_RET   = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  localparam logic [1:0] RIM_ARITH = 2'b00;
  localparam logic [1:0] RIM_MEM   = 2'b01;
  localparam logic [1:0] RIM_CONST = 2'b10;

  typedef struct packed {
    logic       reg_write_enable;
    logic       mem_read_enable;
    logic       mem_write_enable;
    logic       nzp_write_enable;
    logic       decoded_ret;
    logic [1:0] alu_control;
    logic [1:0] reg_input_mux;
    logic       alu_output_mux;
    logic       next_pc_mux;
  } ctrl_t;

endpackage

// File: rtl/decoder.sv
// Per-core instruction decoder: latches operand fields and control strobes
// from the fetched instruction whenever the core scheduler is in DECODE.
module decoder
  import decoder_pkg::*;
#(
  parameter int          INSTR_W      = 16,
  parameter int          REG_ADDR_W   = 4,
  parameter logic [2:0]  DECODE_STATE = CORE_DECODE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            core_state,
  input  logic [INSTR_W-1:0]    instruction,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [7:0]            imm8,
  output logic [2:0]            decoded_nzp,
  output logic                  reg_write_enable,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic                  nzp_write_enable,
  output logic                  decoded_ret,
  output logic [1:0]            alu_control,
  output logic [1:0]            reg_input_mux,
  output logic                  alu_output_mux,
  output logic                  next_pc_mux
);

  logic [3:0]            opcode;
  ctrl_t                 ctrl_d, ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [7:0]            imm8_q;
  logic [2:0]            nzp_q;
  logic                  decode_en;

  assign opcode    = instruction[15:12];
  assign decode_en = (core_state == DECODE_STATE);

  // Undefined opcodes (1010..1110) fall through to the all-zero default.
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OP_BRNZP: ctrl_d.next_pc_mux = 1'b1;
      OP_CMP: begin
        ctrl_d.alu_output_mux   = 1'b1;
        ctrl_d.nzp_write_enable = 1'b1;
      end
      OP_ADD: begin
        ctrl_d.reg_write_enable = 1'b1;
        ctrl_d.reg_input_mux    = RIM_ARITH;
        ctrl_d.alu_control      = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_d.reg_write_enable = 1'b1;
        ctrl_d.reg_input_mux    = RIM_ARITH;
        ctrl_d.alu_control      = ALU_SUB;
      end
      OP_MUL: begin
        ctrl_d.reg_write_enable = 1'b1;
        ctrl_d.reg_input_mux    = RIM_ARITH;
        ctrl_d.alu_control      = ALU_MUL;
      end
      OP_DIV: begin
        ctrl_d.reg_write_enable = 1'b1;
        ctrl_d.reg_input_mux    = RIM_ARITH;
        ctrl_d.alu_control      = ALU_DIV;
      end
      OP_LDR: begin
        ctrl_d.reg_write_enable = 1'b1;
        ctrl_d.reg_input_mux    = RIM_MEM;
        ctrl_d.mem_read_enable  = 1'b1;
      end
      OP_STR: ctrl_d.mem_write_enable = 1'b1;
      OP_CONST: begin
        ctrl_d.reg_write_enable = 1'b1;
        ctrl_d.reg_input_mux    = RIM_CONST;
      end
      OP_RET: ctrl_d.decoded_ret = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      imm8_q <= '0;
      nzp_q  <= '0;
    end else if (decode_en) begin
      ctrl_q <= ctrl_d;
      rd_q   <= instruction[11:8];
      rs_q   <= instruction[7:4];
      rt_q   <= instruction[3:0];
      imm8_q <= instruction[7:0];
      nzp_q  <= instruction[11:9];
    end
  end

  assign rd_addr          = rd_q;
  assign rs_addr          = rs_q;
  assign rt_addr          = rt_q;
  assign imm8             = imm8_q;
  assign decoded_nzp      = nzp_q;
  assign reg_write_enable = ctrl_q.reg_write_enable;
  assign mem_read_enable  = ctrl_q.mem_read_enable;
  assign mem_write_enable = ctrl_q.mem_write_enable;
  assign nzp_write_enable = ctrl_q.nzp_write_enable;
  assign decoded_ret      = ctrl_q.decoded_ret;
  assign alu_control      = ctrl_q.alu_control;
  assign reg_input_mux    = ctrl_q.reg_input_mux;
  assign alu_output_mux   = ctrl_q.alu_output_mux;
  assign next_pc_mux      = ctrl_q.next_pc_mux;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the decoder: the driver pushes the expected register
// image after every clock edge, a negedge monitor pops and compares it.
module tb_decoder;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] imm;
    logic [2:0] nzp;
    logic       rwe;
    logic       mre;
    logic       mwe;
    logic       nwe;
    logic       ret;
    logic [1:0] alu;
    logic [1:0] rim;
    logic       aom;
    logic       npm;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [15:0] instruction;
  logic [3:0]  rd_addr, rs_addr, rt_addr;
  logic [7:0]  imm8;
  logic [2:0]  decoded_nzp;
  logic        reg_write_enable, mem_read_enable, mem_write_enable;
  logic        nzp_write_enable, decoded_ret, alu_output_mux, next_pc_mux;
  logic [1:0]  alu_control, reg_input_mux;

  out_t dut_out;
  out_t model;
  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  always #5 clk = ~clk;

  decoder dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .instruction      (instruction),
    .rd_addr          (rd_addr),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .imm8             (imm8),
    .decoded_nzp      (decoded_nzp),
    .reg_write_enable (reg_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .nzp_write_enable (nzp_write_enable),
    .decoded_ret      (decoded_ret),
    .alu_control      (alu_control),
    .reg_input_mux    (reg_input_mux),
    .alu_output_mux   (alu_output_mux),
    .next_pc_mux      (next_pc_mux)
  );

  assign dut_out = {rd_addr, rs_addr, rt_addr, imm8, decoded_nzp,
                    reg_write_enable, mem_read_enable, mem_write_enable,
                    nzp_write_enable, decoded_ret, alu_control, reg_input_mux,
                    alu_output_mux, next_pc_mux};

  // Reference: fields by shift/modulo, controls from the opcode table rules.
  function automatic out_t spec_decode(input int unsigned ins);
    out_t o;
    int unsigned op;
    op    = (ins >> 12) % 16;
    o     = '0;
    o.rd  = 4'((ins >> 8) % 16);
    o.rs  = 4'((ins >> 4) % 16);
    o.rt  = 4'(ins % 16);
    o.imm = 8'(ins % 256);
    o.nzp = 3'((ins >> 9) % 8);
    o.npm = (op == 1);
    o.aom = (op == 2);
    o.nwe = (op == 2);
    o.rwe = (op >= 3 && op <= 7) || (op == 9);
    o.alu = (op >= 3 && op <= 6) ? 2'(op - 3) : 2'd0;
    o.rim = (op == 7) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    o.mre = (op == 7);
    o.mwe = (op == 8);
    o.ret = (op == 15);
    return o;
  endfunction

  task automatic step(input logic [2:0] st, input logic [15:0] ins);
    core_state  = st;
    instruction = ins;
    @(posedge clk);
    if (reset && st == 3'b010) model = spec_decode(ins);
    exp_q.push_back(model);
    #1;
  endtask

  // Reset dropped between edges must clear outputs before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (dut_out !== '0) begin
      failures++;
      $display("FAIL async_reset actual=%h required=0", dut_out);
    end
    model = '0;
    @(posedge clk);
    exp_q.push_back(model);
    #1 reset = 1'b1;
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_out !== e) begin
          failures++;
          $display("FAIL outputs st=%0d ins=%h actual=%h required=%h",
                   core_state, instruction, dut_out, e);
        end else begin
          $display("ok   st=%0d ins=%h out=%h", core_state, instruction, dut_out);
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] dir_ins [12];
    reset       = 1'b0;
    core_state  = 3'b000;
    instruction = 16'h0000;
    model       = '0;
    @(posedge clk);
    #1;
    step(3'b010, 16'h3123);       // decode while in reset must not load
    step(3'b000, 16'h3123);
    reset = 1'b1;
    step(3'b000, 16'h3123);
    step(3'b000, 16'hFFFF);
    step(3'b010, 16'h3123);       // ADD R1,R2,R3
    step(3'b011, 16'h7456);       // hold outside DECODE
    step(3'b010, 16'h7456);       // LDR
    step(3'b010, 16'h3123);
    async_reset();
    dir_ins = '{16'h2012, 16'h1A07, 16'h9305, 16'h8045, 16'hF000,
                16'h4ABC, 16'h5DEF, 16'h6123, 16'hC000, 16'hA5A5,
                16'hE0FF, 16'h0000};
    foreach (dir_ins[i]) step(3'b010, dir_ins[i]);
    for (int s = 0; s < 8; s++) step(3'(s), 16'h9FFF);
    for (int n = 0; n < 600; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 9) < 4) ? 3'b010 : 3'($urandom_range(0, 7));
      step(st, 16'($urandom));
      if ($urandom_range(0, 59) == 0) async_reset();
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
